// File: rtl/change_dispenser.sv
// Greedy coin payout engine: turns a 6-bit change amount into a stream of
// one-hot coin requests (50/10/5/1), skipping empty tubes and flagging shortfall.
module change_dispenser #(
  parameter int unsigned COIN_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] change,
  input  logic       change_valid,
  output logic       ready,
  output logic       coin_valid,
  output logic [3:0] coin_sel,
  input  logic       coin_ready,
  input  logic [3:0] coin_empty,
  output logic [5:0] remaining,
  output logic [5:0] coin_count,
  output logic       done,
  output logic       short
);

  localparam int unsigned GW       = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;
  localparam int unsigned GAP_LAST = (COIN_GAP > 0) ? COIN_GAP - 1 : 0;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0]      remaining_q, remaining_d;
  logic [5:0]      coin_count_q, coin_count_d;
  logic [3:0]      coin_sel_q, coin_sel_d;
  logic            coin_valid_q, coin_valid_d;
  logic            done_q, done_d;
  logic            short_q, short_d;
  logic            ready_q, ready_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [5:0]      rem_after;
  logic [3:0]      next_sel;

  // Largest denomination that fits and is stocked; all-zero means no coin can be paid.
  function automatic logic [3:0] pick(input logic [5:0] amt, input logic [3:0] empty);
    if (amt >= 6'd50 && !empty[3])     pick = 4'b1000;
    else if (amt >= 6'd10 && !empty[2]) pick = 4'b0100;
    else if (amt >= 6'd5 && !empty[1])  pick = 4'b0010;
    else if (amt >= 6'd1 && !empty[0])  pick = 4'b0001;
    else                                pick = 4'b0000;
  endfunction

  function automatic logic [5:0] coin_value(input logic [3:0] sel);
    case (sel)
      4'b1000: coin_value = 6'd50;
      4'b0100: coin_value = 6'd10;
      4'b0010: coin_value = 6'd5;
      4'b0001: coin_value = 6'd1;
      default: coin_value = 6'd0;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_count_d = coin_count_q;
    coin_sel_d   = coin_sel_q;
    coin_valid_d = coin_valid_q;
    done_d       = 1'b0;
    short_d      = short_q;
    gap_d        = gap_q;
    rem_after    = remaining_q - coin_value(coin_sel_q);
    next_sel     = '0;

    unique case (state_q)
      IDLE: begin
        if (ready_q && change_valid) begin
          remaining_d  = change;
          coin_count_d = '0;
          short_d      = 1'b0;
          next_sel     = pick(change, coin_empty);
          if (change == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (next_sel == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            short_d = 1'b1;
          end else begin
            state_d      = ISSUE;
            coin_valid_d = 1'b1;
            coin_sel_d   = next_sel;
          end
        end
      end
      ISSUE: begin
        if (coin_ready) begin
          remaining_d  = rem_after;
          coin_count_d = coin_count_q + 6'd1;
          next_sel     = pick(rem_after, coin_empty);
          if (rem_after == '0) begin
            state_d      = DONE;
            done_d       = 1'b1;
            coin_valid_d = 1'b0;
            coin_sel_d   = '0;
          end else if (COIN_GAP > 0) begin
            state_d      = GAP;
            coin_valid_d = 1'b0;
            coin_sel_d   = '0;
            gap_d        = '0;
          end else if (next_sel == '0) begin
            state_d      = DONE;
            done_d       = 1'b1;
            short_d      = 1'b1;
            coin_valid_d = 1'b0;
            coin_sel_d   = '0;
          end else begin
            coin_sel_d = next_sel;
          end
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          next_sel = pick(remaining_q, coin_empty);
          if (next_sel == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            short_d = 1'b1;
          end else begin
            state_d      = ISSUE;
            coin_valid_d = 1'b1;
            coin_sel_d   = next_sel;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      coin_count_q <= '0;
      coin_sel_q   <= '0;
      coin_valid_q <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      ready_q      <= 1'b0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_count_q <= coin_count_d;
      coin_sel_q   <= coin_sel_d;
      coin_valid_q <= coin_valid_d;
      done_q       <= done_d;
      short_q      <= short_d;
      ready_q      <= ready_d;
      gap_q        <= gap_d;
    end
  end

  assign ready      = ready_q;
  assign coin_valid = coin_valid_q;
  assign coin_sel   = coin_sel_q;
  assign remaining  = remaining_q;
  assign coin_count = coin_count_q;
  assign done       = done_q;
  assign short      = short_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: one instance with a one-cycle coin gap,
// one back-to-back, sharing stimulus; use_g0 selects which one is observed.
module tb_change_dispenser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, change_valid, coin_ready;
  logic [5:0] change;
  logic [3:0] coin_empty;

  logic       rdy1, cv1, done1, short1;
  logic [3:0] sel1;
  logic [5:0] rem1, cnt1;
  logic       rdy0, cv0, done0, short0;
  logic [3:0] sel0;
  logic [5:0] rem0, cnt0;

  logic       use_g0;
  logic       ready, coin_valid, done, short;
  logic [3:0] coin_sel;
  logic [5:0] remaining, coin_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q [$];

  change_dispenser #(.COIN_GAP(1)) dut_g1 (
    .clk(clk), .rst(rst), .change(change), .change_valid(change_valid),
    .ready(rdy1), .coin_valid(cv1), .coin_sel(sel1), .coin_ready(coin_ready),
    .coin_empty(coin_empty), .remaining(rem1), .coin_count(cnt1),
    .done(done1), .short(short1)
  );

  change_dispenser #(.COIN_GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .change(change), .change_valid(change_valid),
    .ready(rdy0), .coin_valid(cv0), .coin_sel(sel0), .coin_ready(coin_ready),
    .coin_empty(coin_empty), .remaining(rem0), .coin_count(cnt0),
    .done(done0), .short(short0)
  );

  assign ready      = use_g0 ? rdy0   : rdy1;
  assign coin_valid = use_g0 ? cv0    : cv1;
  assign coin_sel   = use_g0 ? sel0   : sel1;
  assign remaining  = use_g0 ? rem0   : rem1;
  assign coin_count = use_g0 ? cnt0   : cnt1;
  assign done       = use_g0 ? done0  : done1;
  assign short      = use_g0 ? short0 : short1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] amt);
    check("ready_before_load", ready, 1);
    change       = amt;
    change_valid = 1'b1;
    tick();
    change_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rdy0 && rdy1) && n < 300) begin
      tick();
      n++;
    end
    check("idle_reached", rdy0 && rdy1, 1);
  endtask

  // Expects coin_ready=1; each coin is accepted on the edge after it is seen.
  task automatic expect_coins(input int gap);
    int idle;
    for (int i = 0; i < exp_q.size(); i++) begin
      idle = 0;
      while (!coin_valid && idle < 20) begin
        tick();
        idle++;
      end
      check("coin_gap", idle, (i == 0) ? 0 : gap);
      check("coin_sel", coin_sel, exp_q[i]);
      tick();
    end
  endtask

  task automatic wait_done(input int lat, input logic sh, input logic [5:0] rem,
                           input logic [5:0] cnt);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("done_latency", n, lat);
    check("done", done, 1);
    check("short", short, sh);
    check("remaining", remaining, rem);
    check("coin_count", coin_count, cnt);
    check("coin_valid_at_done", coin_valid, 0);
    check("ready_at_done", ready, 0);
    tick();
    check("done_pulse_width", done, 0);
    check("ready_after_done", ready, 1);
  endtask

  initial begin
    rst = 1'b1; change = '0; change_valid = 1'b0; coin_ready = 1'b1;
    coin_empty = '0; use_g0 = 1'b0;
    tick();
    tick();
    check("rst_coin_valid", coin_valid, 0);
    check("rst_coin_sel", coin_sel, 0);
    check("rst_remaining", remaining, 0);
    check("rst_coin_count", coin_count, 0);
    check("rst_done", done, 0);
    check("rst_short", short, 0);
    check("rst_ready", ready, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", ready, 1);

    // 38 = 10+10+10+5+1+1+1 with one idle cycle between coins
    exp_q = '{4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
    load(6'd38);
    expect_coins(1);
    wait_done(0, 1'b0, 6'd0, 6'd7);

    // zero change completes immediately without a coin
    wait_idle();
    load(6'd0);
    check("zero_no_coin", coin_valid, 0);
    wait_done(0, 1'b0, 6'd0, 6'd0);

    // 63 back-to-back with 3 cycles of backpressure on the 50 coin
    wait_idle();
    use_g0 = 1'b1;
    coin_ready = 1'b0;
    load(6'd63);
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", coin_valid, 1);
      check("bp_sel", coin_sel, 4'b1000);
      tick();
    end
    check("bp_sel_last", coin_sel, 4'b1000);
    coin_ready   = 1'b1;
    change       = 6'd5;
    change_valid = 1'b1;
    tick();
    change_valid = 1'b0;
    exp_q = '{4'b0100, 4'b0001, 4'b0001, 4'b0001};
    expect_coins(0);
    wait_done(0, 1'b0, 6'd0, 6'd5);
    tick();
    check("ignored_load_no_coin", coin_valid, 0);
    check("ignored_load_remaining", remaining, 0);
    use_g0 = 1'b0;

    // 10-tube empty: 27 = 5*5 + 1+1
    wait_idle();
    coin_empty = 4'b0100;
    exp_q = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
    load(6'd27);
    expect_coins(1);
    wait_done(0, 1'b0, 6'd0, 6'd7);

    // 1-tube empty: 8 pays one 5 then faults after the gap with 3 owed
    wait_idle();
    coin_empty = 4'b0001;
    exp_q = '{4'b0010};
    load(6'd8);
    expect_coins(1);
    wait_done(1, 1'b1, 6'd3, 6'd1);

    // reset after the first coin of 62 discards the rest
    wait_idle();
    coin_empty = '0;
    load(6'd62);
    check("r_first_sel", coin_sel, 4'b1000);
    tick();
    check("r_rem_after_50", remaining, 12);
    check("r_cnt_after_50", coin_count, 1);
    rst = 1'b1;
    tick();
    check("r_coin_valid", coin_valid, 0);
    check("r_remaining", remaining, 0);
    check("r_coin_count", coin_count, 0);
    check("r_done", done, 0);
    check("r_ready", ready, 0);
    rst = 1'b0;
    tick();
    check("r_ready_after", ready, 1);
    check("r_no_done", done, 0);
    tick();
    check("r_no_coin", coin_valid, 0);
    exp_q = '{4'b0010};
    load(6'd5);
    expect_coins(1);
    wait_done(0, 1'b0, 6'd0, 6'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream of the vending machine controller. Takes the 6-bit change amount the controller produces on a purchase or cancel and pays it out as a sequence of individual coins (50, 10, 5, 1) to a coin hopper. Pays greedily, largest available denomination first, with a valid/ready handshake per coin. Skips empty hopper tubes and reports any shortfall when exact change cannot be paid.

## Interface
- COIN_GAP, 1, idle cycles inserted between an accepted coin and the next coin_valid (0 = back-to-back)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- change  in  6  amount to pay out, 0..63
- change_valid  in  1  load strobe; sampled only when ready=1
- ready  out  1  block idle and able to accept a new amount
- coin_valid  out  1  coin request to hopper
- coin_sel  out  4  one-hot denomination: [3]=50, [2]=10, [1]=5, [0]=1
- coin_ready  in  1  hopper accepts current coin this cycle
- coin_empty  in  4  per-tube empty flags, same bit order as coin_sel
- remaining  out  6  amount still owed
- coin_count  out  6  coins accepted in current/last transaction
- done  out  1  one-cycle pulse, transaction finished
- short  out  1  valid with done; exact change could not be paid

## Operation
- All outputs are registered.
- States: IDLE, ISSUE, GAP, DONE.
- **Reset:** state=IDLE, coin_valid=0, coin_sel=0, remaining=0, coin_count=0, done=0, short=0. ready is 0 in the reset cycle and 1 from the first cycle after rst falls.
- **Selection function:**
  - Denomination d is eligible if d ≤ remaining and coin_empty[d]=0.
  - coin_sel = largest eligible d.
  - If no d is eligible while remaining>0, the result is fault.
  - Evaluated only when entering ISSUE. coin_sel is frozen while coin_valid=1, and a coin_empty change during a pending request has no effect on it.
- **IDLE:**
  - ready=1.
  - On change_valid, latch remaining=change and clear coin_count and short.
  - change=0 → DONE.
  - Otherwise evaluate selection: fault → DONE with short=1; else → ISSUE.
- **ISSUE:**
  - coin_valid=1.
  - On coin_ready: remaining -= value(coin_sel) and coin_count += 1.
  - New remaining=0 → DONE.
  - Else COIN_GAP>0 → GAP (coin_valid=0).
  - Else re-evaluate selection and stay in ISSUE (fault → DONE, short=1).
- **GAP:**
  - Count COIN_GAP cycles with coin_valid=0.
  - Then evaluate selection: → ISSUE, or fault → DONE with short=1.
- **DONE:**
  - done=1 for exactly one cycle, then → IDLE.
  - remaining and coin_count hold until the next load. On short, remaining equals the unpaid amount.
- change_valid while ready=0 is ignored; it is neither queued nor merged.
- remaining never underflows, because the selection function guarantees d ≤ remaining.

## Timing
- change_valid sampled at edge T → coin_valid=1 from cycle T+1.
- change_valid sampled at edge T with change=0 → done in cycle T+1, coin_valid never asserted.
- A coin is transferred on each edge where coin_valid=1 and coin_ready=1.
- After that edge:
  - COIN_GAP=0 → next coin_valid in the following cycle.
  - Otherwise coin_valid is low for COIN_GAP cycles.
- Final accept at edge E → done=1 in cycle E+1 → ready=1 in cycle E+2.
- coin_ready low for N cycles extends ISSUE by N cycles. coin_valid and coin_sel stay unchanged throughout.
- rst mid-transaction:
  - Next cycle coin_valid=0 and all outputs take reset values.
  - No done pulse.
  - The undispensed amount is discarded.
- rst has priority over change_valid and coin_ready in the same cycle.

## Test plan
- **Basic payout:** change=38, no empties, coin_ready=1, COIN_GAP=1 → coin_sel sequence 10,10,10,5,1,1,1 (4'b0100 ×3, 4'b0010, 4'b0001 ×3), each coin_valid one cycle with one idle cycle between. Then done=1, short=0, remaining=0, coin_count=7, ready back two cycles after the last accept.
- **Zero change:** change=0 with change_valid → done one cycle later, coin_valid never high, coin_count=0.
- **Max value and backpressure:** change=63, COIN_GAP=0, coin_ready held low 3 cycles on the first coin → coin_sel=4'b1000 stable for 4 cycles. Then 10,1,1,1 back-to-back, coin_count=5. A change_valid pulse mid-payout is ignored.
- **Empty tube skip:** coin_empty=4'b0100, change=27 → 5,5,5,5,5,1,1; coin_count=7, short=0.
- **Shortfall:** coin_empty=4'b0001, change=8 → one 5 coin, then done=1, short=1, remaining=3, coin_count=1.
- **Reset mid-dispense:** change=50+10+2, rst asserted after the first accept → coin_valid=0 the next cycle, remaining=0, coin_count=0, no done pulse, ready=1 after rst falls. A new change=5 then pays a single 5 coin.
